// File: rtl/bldc_commutator.sv
`default_nettype none
// =============================================================================
// bldc_commutator : six-step BLDC commutation with dead time, PWM gating,
//                   fault/hall-error blanking and step-period measurement.
// Revision        : 1.0
// =============================================================================
module bldc_commutator #(
  parameter int unsigned DTI_CYCLES = 1024,
  parameter int unsigned PERIOD_W   = 24
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [2:0]          hall,
  input  logic                dir,
  input  logic                enable,
  input  logic                pwm_in,
  input  logic                fault_n,
  input  logic                clear_fault,
  output logic                inha,
  output logic                inla,
  output logic                inhb,
  output logic                inlb,
  output logic                inhc,
  output logic                inlc,
  output logic [2:0]          sector,
  output logic                hall_error,
  output logic                fault,
  output logic [PERIOD_W-1:0] step_period,
  output logic                step_valid
);

  localparam logic [1:0]          ST_OFF   = 2'd0;
  localparam logic [1:0]          ST_DEAD  = 2'd1;
  localparam logic [1:0]          ST_DRIVE = 2'd2;
  localparam logic [1:0]          ST_HERR  = 2'd3;
  localparam logic [2:0]          SEC_INV  = 3'd7;
  localparam logic [15:0]         DT_LOAD  = 16'(DTI_CYCLES - 1);
  localparam logic [PERIOD_W-1:0] CNT_MAX  = '1;

  function automatic logic [2:0] decode(input logic [2:0] h);
    case (h)
      3'b101:  decode = 3'd0;
      3'b100:  decode = 3'd1;
      3'b110:  decode = 3'd2;
      3'b010:  decode = 3'd3;
      3'b011:  decode = 3'd4;
      3'b001:  decode = 3'd5;
      default: decode = SEC_INV;
    endcase
  endfunction

  // Pattern word is {gl[c:a], gh[c:a]}.
  function automatic logic [5:0] pattern(input logic [2:0] s, input logic d);
    case ({d, s})
      4'b1_000: pattern = 6'b010_100;
      4'b1_001: pattern = 6'b010_001;
      4'b1_010: pattern = 6'b100_001;
      4'b1_011: pattern = 6'b100_010;
      4'b1_100: pattern = 6'b001_010;
      4'b1_101: pattern = 6'b001_100;
      4'b0_000: pattern = 6'b100_010;
      4'b0_001: pattern = 6'b001_010;
      4'b0_010: pattern = 6'b001_100;
      4'b0_011: pattern = 6'b010_100;
      4'b0_100: pattern = 6'b010_001;
      4'b0_101: pattern = 6'b100_001;
      default:  pattern = 6'b000_000;
    endcase
  endfunction

  logic [1:0]          state_q, state_d;
  logic [2:0]          sector_q;
  logic                herr_q;
  logic                fault_q;
  logic [15:0]         dt_cnt_q;
  logic [2:0]          tgt_sec_q;
  logic                tgt_dir_q;
  logic [5:0]          gates_q, gates_d;
  logic [2:0]          prev_sec_q;
  logic [PERIOD_W-1:0] cnt_q;
  logic [PERIOD_W-1:0] period_q;
  logic                svalid_q;

  logic change;
  logic blank;
  logic dt_load;
  logic step_det;

  // Target is the (sector, dir) latched when dead time started.
  assign change   = (sector_q != tgt_sec_q) || (dir != tgt_dir_q);
  assign blank    = fault_q || !fault_n || !enable;
  assign dt_load  = (state_d == ST_DEAD) && ((state_q != ST_DEAD) || change);
  assign step_det = (sector_q != SEC_INV) && (prev_sec_q != SEC_INV) &&
                    (sector_q != prev_sec_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_OFF;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (blank) begin
      state_d = ST_OFF;
    end else if (sector_q == SEC_INV) begin
      state_d = ST_HERR;
    end else begin
      case (state_q)
        ST_OFF, ST_HERR: state_d = ST_DEAD;
        ST_DEAD:         if (!change && dt_cnt_q == 16'd0) state_d = ST_DRIVE;
        ST_DRIVE:        if (change) state_d = ST_DEAD;
        default:         state_d = ST_OFF;
      endcase
    end
  end

  always_comb begin
    gates_d = 6'b000_000;
    if (state_d == ST_DRIVE) begin
      gates_d = pattern(sector_q, dir);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sector_q  <= SEC_INV;
      herr_q    <= 1'b0;
      fault_q   <= 1'b0;
      dt_cnt_q  <= 16'd0;
      tgt_sec_q <= SEC_INV;
      tgt_dir_q <= 1'b0;
      gates_q   <= 6'b000_000;
    end else begin
      sector_q <= decode(hall);
      herr_q   <= (hall == 3'b000) || (hall == 3'b111);
      gates_q  <= gates_d;
      if (!fault_n) begin
        fault_q <= 1'b1;
      end else if (clear_fault) begin
        fault_q <= 1'b0;
      end
      // A target change while already in dead time restarts the full interval.
      if (dt_load) begin
        dt_cnt_q  <= DT_LOAD;
        tgt_sec_q <= sector_q;
        tgt_dir_q <= dir;
      end else if (state_q == ST_DEAD && dt_cnt_q != 16'd0) begin
        dt_cnt_q <= dt_cnt_q - 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_sec_q <= SEC_INV;
      cnt_q      <= '0;
      period_q   <= '0;
      svalid_q   <= 1'b0;
    end else begin
      prev_sec_q <= sector_q;
      svalid_q   <= step_det;
      if (step_det) begin
        period_q <= cnt_q;
        cnt_q    <= PERIOD_W'(1);
      end else if (cnt_q != CNT_MAX) begin
        cnt_q <= cnt_q + PERIOD_W'(1);
      end
    end
  end

  assign inha        = gates_q[0] & pwm_in;
  assign inhb        = gates_q[1] & pwm_in;
  assign inhc        = gates_q[2] & pwm_in;
  assign inla        = gates_q[3];
  assign inlb        = gates_q[4];
  assign inlc        = gates_q[5];
  assign sector      = sector_q;
  assign hall_error  = herr_q;
  assign fault       = fault_q;
  assign step_period = period_q;
  assign step_valid  = svalid_q;

endmodule
`default_nettype wire

// File: tb/tb_bldc_commutator.sv
`default_nettype none
// =============================================================================
// tb_bldc_commutator : self-checking bench for bldc_commutator.
// Revision           : 1.0
// =============================================================================
module tb_bldc_commutator;

  localparam int DTI  = 16;
  localparam int PW   = 12;
  localparam int HOLD = 200;
  localparam int SAT  = (1 << PW) - 1;

  logic clk = 1'b0;
  logic reset_n, dir, enable, pwm_in, fault_n, clear_fault;
  logic [2:0] hall;
  logic inha, inla, inhb, inlb, inhc, inlc;
  logic [2:0] sector;
  logic hall_error, fault, step_valid;
  logic [PW-1:0] step_period;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [2:0] hall;
    logic [2:0] sec;
    logic [5:0] gates;
  } vec_t;

  typedef struct {
    bit          care;
    int unsigned val;
  } exp_t;

  exp_t sb_q[$];
  bit   mon_en = 1'b0;

  bldc_commutator #(.DTI_CYCLES(DTI), .PERIOD_W(PW)) dut (
    .clk(clk), .reset_n(reset_n), .hall(hall), .dir(dir), .enable(enable),
    .pwm_in(pwm_in), .fault_n(fault_n), .clear_fault(clear_fault),
    .inha(inha), .inla(inla), .inhb(inhb), .inlb(inlb), .inhc(inhc), .inlc(inlc),
    .sector(sector), .hall_error(hall_error), .fault(fault),
    .step_period(step_period), .step_valid(step_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [5:0] gates();
    return {inlc, inlb, inla, inhc, inhb, inha};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts all-low samples until the gates come back on (bounded).
  task automatic wait_drive(output int zeros);
    zeros = 0;
    tick();
    while (gates() == 6'b0 && zeros < 8 * DTI) begin
      zeros++;
      tick();
    end
  endtask

  // Scoreboard for step_period plus a per-cycle cross-conduction check.
  always @(posedge clk) begin
    #1;
    if (mon_en) begin
      chk("no_shoot_through",
          {31'd0, ($countones({inhc, inhb, inha}) <= 1) &&
                  ($countones({inlc, inlb, inla}) <= 1) &&
                  (({inhc, inhb, inha} & {inlc, inlb, inla}) == 3'b0)}, 32'd1);
      if (step_valid) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_step_valid", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          if (e.care) chk("step_period", 32'(step_period), e.val);
        end
      end
    end
  end

  initial begin
    vec_t rot[6];
    int   z;
    rot[0] = '{3'b101, 3'd0, 6'b010_100};
    rot[1] = '{3'b100, 3'd1, 6'b010_001};
    rot[2] = '{3'b110, 3'd2, 6'b100_001};
    rot[3] = '{3'b010, 3'd3, 6'b100_010};
    rot[4] = '{3'b011, 3'd4, 6'b001_010};
    rot[5] = '{3'b001, 3'd5, 6'b001_100};

    reset_n = 1'b0; hall = 3'b100; dir = 1'b1; enable = 1'b1;
    pwm_in = 1'b1; fault_n = 1'b1; clear_fault = 1'b0;
    repeat (3) tick();
    chk("rst_gates", 32'(gates()), 32'd0);
    chk("rst_sector", 32'(sector), 32'd7);
    chk("rst_hall_error", 32'(hall_error), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_step_period", 32'(step_period), 32'd0);
    chk("rst_step_valid", 32'(step_valid), 32'd0);

    // Startup: sector latch, OFF->DEADTIME, then DTI all-low cycles.
    reset_n = 1'b1;
    mon_en  = 1'b1;
    wait_drive(z);
    chk("startup_low_cycles", 32'(z), 32'(DTI + 1));
    chk("startup_pattern_B", 32'(gates()), 32'b010_001);
    pwm_in = 1'b0;
    #1;
    chk("pwm_off_only_inha", 32'(gates()), 32'b010_000);
    pwm_in = 1'b1;
    #1;
    chk("pwm_on_inha", 32'(gates()), 32'b010_001);

    for (int i = 0; i < 6; i++) begin
      hall = rot[i].hall;
      sb_q.push_back('{i != 0, HOLD});
      tick();
      chk($sformatf("rot%0d_sector", i), 32'(sector), 32'(rot[i].sec));
      wait_drive(z);
      chk($sformatf("rot%0d_deadtime", i), 32'(z), 32'(DTI));
      chk($sformatf("rot%0d_pattern", i), 32'(gates()), 32'(rot[i].gates));
      repeat (HOLD - DTI - 2) tick();
    end

    // Direction reversal while in sector C.
    hall = 3'b110;
    sb_q.push_back('{1'b1, HOLD});
    tick();
    wait_drive(z);
    chk("C_fwd_pattern", 32'(gates()), 32'b100_001);
    dir = 1'b0;
    wait_drive(z);
    chk("dir_flip_deadtime", 32'(z), 32'(DTI));
    chk("C_rev_pattern", 32'(gates()), 32'b001_100);
    repeat (5) tick();

    // Invalid hall excursion.
    hall = 3'b111;
    tick();
    chk("herr_flag", 32'(hall_error), 32'd1);
    chk("herr_sector", 32'(sector), 32'd7);
    tick();
    chk("herr_gates_low", 32'(gates()), 32'd0);
    hall = 3'b110;
    tick();
    chk("herr_clear", 32'(hall_error), 32'd0);
    wait_drive(z);
    chk("herr_return_deadtime", 32'(z), 32'(DTI));
    chk("herr_return_pattern", 32'(gates()), 32'b001_100);
    chk("herr_period_kept", 32'(step_period), 32'(HOLD));

    // Driver fault latch and clear.
    fault_n = 1'b0;
    tick();
    chk("fault_gates_low", 32'(gates()), 32'd0);
    chk("fault_set", 32'(fault), 32'd1);
    fault_n = 1'b1;
    tick();
    chk("fault_latched", 32'(fault), 32'd1);
    chk("fault_latched_gates", 32'(gates()), 32'd0);
    fault_n = 1'b0; clear_fault = 1'b1;
    tick();
    chk("fault_clear_ignored", 32'(fault), 32'd1);
    fault_n = 1'b1;
    tick();
    clear_fault = 1'b0;
    chk("fault_cleared", 32'(fault), 32'd0);
    wait_drive(z);
    chk("fault_recover_deadtime", 32'(z), 32'(DTI));
    chk("fault_recover_pattern", 32'(gates()), 32'b001_100);

    enable = 1'b0;
    tick();
    chk("disable_gates_low", 32'(gates()), 32'd0);
    enable = 1'b1;
    wait_drive(z);
    chk("enable_deadtime", 32'(z), 32'(DTI));

    // Long hold saturates the period counter.
    repeat (SAT + 10) tick();
    hall = 3'b010;
    sb_q.push_back('{1'b1, SAT});
    repeat (2) tick();
    chk("sat_step_valid", 32'(step_valid), 32'd1);
    repeat (3) tick();
    chk("dt_mid_gates_low", 32'(gates()), 32'd0);

    // Asynchronous reset mid-dead-time.
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("async_rst_sector", 32'(sector), 32'd7);
    chk("async_rst_period", 32'(step_period), 32'd0);
    chk("async_rst_gates", 32'(gates()), 32'd0);
    chk("async_rst_fault", 32'(fault), 32'd0);
    chk("async_rst_step_valid", 32'(step_valid), 32'd0);
    mon_en = 1'b0;
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
